xpb_lut_sequencer: RTL



---
 rtl/xpb_lut_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/xpb_lut_sequencer.sv
// xpb_lut_sequencer: issues one digit per cycle to the xpb LUT bank and accumulates the returned constants
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_valid/start_ready digit-vector handshake; digits_in holds NUM_DIGITS packed DIGIT_W digits
//   lut_sel, lut_idx        bank select (digit position) and index into the selected LUT
//   lut_data                combinational LUT bank output for {lut_sel, lut_idx}
//   res_valid/res_ready     result handshake; res_data is the unreduced ACC_W-bit sum
//   busy                    high whenever the sequencer is not idle
//
// Build option: define XPB_SEQ_SKIP_ZERO_EN to issue only the non-zero digits.
module xpb_lut_sequencer #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 5,
    parameter int DATA_W     = 1024,
    parameter int ACC_W      = 1028,
    parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [DIGIT_W-1:0]            lut_idx,
    input  logic [DATA_W-1:0]             lut_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_W-1:0]              res_data,
    output logic                          busy
);
    if (ACC_W < DATA_W + $clog2(NUM_DIGITS) + 1) begin : g_acc_w_check
        $error("xpb_lut_sequencer: ACC_W too narrow for NUM_DIGITS * DATA_W sum");
    end
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t                               state_q, state_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   digit_q;
    logic [DATA_W-1:0]                    pipe_q;
    logic                                 pipe_v_q;
    logic [ACC_W-1:0]                     acc_q, acc_d;
    logic [SEL_W-1:0]                     cur_sel;
    logic                                 last_issue;
    logic                                 has_work;
    logic                                 accept;
    assign accept = (state_q == IDLE) && start_valid;
    // The registered constant from the previous issue cycle is folded in one edge later.
    assign acc_d  = acc_q + (pipe_v_q ? ACC_W'(pipe_q) : '0);
`ifdef XPB_SEQ_SKIP_ZERO_EN
    logic [NUM_DIGITS-1:0] mask_q, mask_nz, mask_rest;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nz
        assign mask_nz[i] = |digits_in[i*DIGIT_W +: DIGIT_W];
    end
    // Clearing the lowest set bit leaves exactly the positions still to be issued.
    assign mask_rest  = mask_q & (mask_q - NUM_DIGITS'(1));
    assign last_issue = mask_rest == '0;
    assign has_work   = |mask_nz;
    always_comb begin
        cur_sel = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (mask_q[i]) cur_sel = SEL_W'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else if (accept) mask_q <= mask_nz;
        else if (state_q == ISSUE) mask_q <= mask_rest;
    end
`else
    logic [SEL_W-1:0] idx_q;
    assign cur_sel    = idx_q;
    assign last_issue = idx_q == SEL_W'(NUM_DIGITS - 1);
    assign has_work   = 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= '0;
        else if (accept) idx_q <= '0;
        else if (state_q == ISSUE) idx_q <= idx_q + SEL_W'(1);
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_d = has_work ? ISSUE : DRAIN;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        start_ready = state_q == IDLE;
        busy        = state_q != IDLE;
        res_valid   = state_q == DONE;
        res_data    = (state_q == DONE) ? acc_q : '0;
        lut_sel     = (state_q == ISSUE) ? cur_sel : '0;
        lut_idx     = (state_q == ISSUE) ? digit_q[cur_sel] : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q  <= '0;
            pipe_q   <= '0;
            pipe_v_q <= 1'b0;
            acc_q    <= '0;
        end else if (accept) begin
            digit_q  <= digits_in;
            pipe_v_q <= 1'b0;
            acc_q    <= '0;
        end else if (state_q == ISSUE) begin
            pipe_q   <= lut_data;
            pipe_v_q <= 1'b1;
            acc_q    <= acc_d;
        end else if (state_q == DRAIN) begin
            pipe_v_q <= 1'b0;
            acc_q    <= acc_d;
        end
    end
endmodule
